// File: rtl/cgol_gen_sched.sv
// Generation scheduler for a toroidal Game-of-Life board held in two row files.
// Walks the rows through COMPUTE (read prev-state, write next-state one cycle
// later), COPY (next-state back into prev-state), a one-cycle commit, and a
// DWELL hold so the board can be displayed before the next generation.
// The commit cycle belongs to DWELL: dwell counter value 0 is the commit cycle
// (gen_done), values 1..DWELL are the display hold.
// Handshake: load_req/load_ack is level based -- load_ack stays high for as
// long as load_req is held once LOAD is entered, and drops the cycle after
// load_req falls; the external writer owns both row files only while load_ack=1.
module cgol_gen_sched #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int DWELL   = 16,
  parameter int GENBITS = 16
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               load_req,
  output logic               load_ack,
  output logic               busy,
  output logic [REGBITS-1:0] rd_up,
  output logic [REGBITS-1:0] rd_mid,
  output logic [REGBITS-1:0] rd_dn,
  output logic               wr_en,
  output logic [REGBITS-1:0] wr_addr,
  output logic               cp_en,
  output logic [REGBITS-1:0] cp_addr,
  output logic               gen_done,
  output logic [GENBITS-1:0] gen_count,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_COPY    = 3'd3,
    S_DWELL   = 3'd4
  } state_t;

  // COMPUTE runs one extra cycle (row counter = WIDTH) to flush the last write.
  localparam logic [REGBITS:0] ROW_LAST_COMPUTE = (REGBITS+1)'(WIDTH);
  localparam logic [REGBITS:0] ROW_LAST_COPY    = (REGBITS+1)'(WIDTH - 1);
  localparam logic [7:0]       DWELL_LAST       = 8'(DWELL);

  state_t               state_q, state_d;
  logic [REGBITS:0]     row_q, row_d;
  logic [7:0]           dwell_q, dwell_d;
  logic [GENBITS-1:0]   gen_q, gen_d;
  logic [REGBITS-1:0]   row_lo;

  assign row_lo = row_q[REGBITS-1:0];

  // State register: synchronous active-low reset dominates everything.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      dwell_q <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      gen_q   <= gen_d;
    end
  end

  // Next-state logic: sequencing of rows, dwell hold and generation count.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    gen_d   = gen_q;
    case (state_q)
      S_IDLE: begin
        row_d   = '0;
        dwell_d = '0;
        if (load_req)          state_d = S_LOAD;
        else if (step || run)  state_d = S_COMPUTE;
      end
      S_LOAD: begin
        if (!load_req) state_d = S_IDLE;
      end
      S_COMPUTE: begin
        if (row_q == ROW_LAST_COMPUTE) begin
          state_d = S_COPY;
          row_d   = '0;
        end else begin
          row_d = row_q + (REGBITS+1)'(1);
        end
      end
      S_COPY: begin
        if (row_q == ROW_LAST_COPY) begin
          state_d = S_DWELL;
          row_d   = '0;
          dwell_d = '0;
          gen_d   = gen_q + GENBITS'(1);
        end else begin
          row_d = row_q + (REGBITS+1)'(1);
        end
      end
      S_DWELL: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          row_d   = '0;
          // A pending load wins over free-run; step is not looked at here.
          if (load_req)  state_d = S_IDLE;
          else if (run)  state_d = S_COMPUTE;
          else           state_d = S_IDLE;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        row_d   = '0;
        dwell_d = '0;
      end
    endcase
  end

  // Output decode: everything is a function of the registered state only.
  always_comb begin
    load_ack = 1'b0;
    busy     = 1'b0;
    rd_up    = '0;
    rd_mid   = '0;
    rd_dn    = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    cp_en    = 1'b0;
    cp_addr  = '0;
    gen_done = 1'b0;
    case (state_q)
      S_LOAD: load_ack = 1'b1;
      S_COMPUTE: begin
        busy = 1'b1;
        if (!row_q[REGBITS]) begin
          // WIDTH is a power of two, so address wrap is plain modular arithmetic.
          rd_mid = row_lo;
          rd_up  = row_lo - REGBITS'(1);
          rd_dn  = row_lo + REGBITS'(1);
        end
        if (row_q != '0) begin
          wr_en   = 1'b1;
          wr_addr = row_lo - REGBITS'(1);
        end
      end
      S_COPY: begin
        busy    = 1'b1;
        cp_en   = 1'b1;
        cp_addr = row_lo;
      end
      S_DWELL: begin
        busy     = 1'b1;
        gen_done = (dwell_q == 8'd0);
      end
      default: ;
    endcase
  end

  assign gen_count = gen_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cgol_gen_sched.sv
// Bench for cgol_gen_sched: a generation-timeline model predicts every output
// each cycle; directed scenarios add literal expectations (lengths, offsets,
// addresses, counts) that pin the model; a long random phase follows.
module tb_cgol_gen_sched;

  localparam int W    = 8;
  localparam int RB   = 3;
  localparam int DW   = 16;
  localparam int GB   = 4;
  localparam int EW   = 2 + 3*RB + 1 + RB + 1 + RB + 1 + GB;
  // Generation timeline: t=0..W compute, W+1..2W copy, 2W+1 commit, then DW hold.
  localparam int T_COMMIT = 2*W + 1;
  localparam int T_LAST   = 2*W + 1 + DW;

  // ---------------- clock / reset / DUT ----------------
  logic ph1 = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0, step = 1'b0, load_req = 1'b0;
  logic load_ack, busy, wr_en, cp_en, gen_done;
  logic [RB-1:0] rd_up, rd_mid, rd_dn, wr_addr, cp_addr;
  logic [GB-1:0] gen_count;
  logic [2:0] dbg_state;

  always #5 ph1 = ~ph1;

  cgol_gen_sched #(.WIDTH(W), .REGBITS(RB), .DWELL(DW), .GENBITS(GB)) dut (
    .ph1(ph1), .reset(reset), .run(run), .step(step), .load_req(load_req),
    .load_ack(load_ack), .busy(busy), .rd_up(rd_up), .rd_mid(rd_mid),
    .rd_dn(rd_dn), .wr_en(wr_en), .wr_addr(wr_addr), .cp_en(cp_en),
    .cp_addr(cp_addr), .gen_done(gen_done), .gen_count(gen_count),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 load, 2 inside a generation at timeline index m_t.
  int m_mode = 0;
  int m_t = 0;
  int m_gc = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] expect_vec(input int mode, input int t, input int gc);
    logic la, bz, we, ce, gd;
    logic [RB-1:0] up, mid, dn, wa, ca;
    la = (mode == 1); bz = (mode == 2);
    we = 1'b0; ce = 1'b0; gd = 1'b0;
    up = '0; mid = '0; dn = '0; wa = '0; ca = '0;
    if (mode == 2) begin
      if (t < W) begin
        mid = RB'(t);
        up  = RB'((t + W - 1) % W);
        dn  = RB'((t + 1) % W);
      end
      if (t >= 1 && t <= W) begin we = 1'b1; wa = RB'(t - 1); end
      if (t >= W + 1 && t <= 2*W) begin ce = 1'b1; ca = RB'(t - W - 1); end
      gd = (t == T_COMMIT);
    end
    return {la, bz, up, mid, dn, we, wa, ce, ca, gd, GB'(gc)};
  endfunction

  always @(posedge ph1) begin : model
    int mode_n, t_n, gc_n;
    mode_n = m_mode; t_n = m_t; gc_n = m_gc;
    if (!reset) begin
      mode_n = 0; t_n = 0; gc_n = 0;
    end else begin
      case (m_mode)
        0: if (load_req) mode_n = 1;
           else if (step || run) begin mode_n = 2; t_n = 0; end
        1: if (!load_req) mode_n = 0;
        default: begin
          if (m_t == T_LAST) begin
            if (load_req)  mode_n = 0;
            else if (run)  t_n = 0;
            else           mode_n = 0;
          end else begin
            t_n = m_t + 1;
            if (t_n == T_COMMIT) gc_n = (m_gc + 1) % (1 << GB);
          end
        end
      endcase
    end
    exp_q.push_back(expect_vec(mode_n, t_n, gc_n));
    m_mode <= mode_n;
    m_t    <= t_n;
    m_gc   <= gc_n;
  end

  // ---------------- scoreboard / compare process ----------------
  int checks = 0;
  int errors = 0;
  logic  lit_on = 1'b0;
  string lit_name = "";
  int    lit_act = 0;
  int    lit_exp = 0;

  always @(negedge ph1) begin : compare
    logic [EW-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {load_ack, busy, rd_up, rd_mid, rd_dn, wr_en, wr_addr, cp_en, cp_addr, gen_done, gen_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model_outputs @%0t act=%h exp=%h", $time, a, e);
      end
    end
    if (lit_on) begin
      checks++;
      if (lit_act != lit_exp) begin
        errors++;
        $display("FAIL %s act=%0d exp=%0d", lit_name, lit_act, lit_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge ph1); #1;
  endtask

  task automatic post(input string nm, input int act, input int exp);
    lit_name = nm; lit_act = act; lit_exp = exp; lit_on = 1'b1;
    @(negedge ph1); #1;
    lit_on = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0; load_req = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  function automatic int all_outs();
    return int'({load_ack, busy, rd_up, rd_mid, rd_dn, wr_en, wr_addr, cp_en, cp_addr, gen_done, gen_count});
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stim
    int n, busy_len, done_at, first_wr, t0_trip, t7_trip, cp_first, timeouts;
    int dones, gaps, gc3, gc4, strobes, v, gc15, gc16;
    bit started;
    timeouts = 0;

    // Reset state
    do_reset();
    cyc();
    post("rst_gen_count", int'(gen_count), 0);
    post("rst_all_outputs", all_outs(), 0);

    // Single step with run=0: lengths, offsets and row walk
    step = 1'b1; cyc(); step = 1'b0;
    n = 0; busy_len = 0; done_at = -1; first_wr = -1; cp_first = -1;
    t0_trip = -1; t7_trip = -1; started = 0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) cyc();
      if (busy) begin
        started = 1; n++; busy_len++;
        if (n == 1) t0_trip = int'({rd_up, rd_mid, rd_dn});
        if (n == 8) t7_trip = int'({rd_up, rd_mid, rd_dn});
        if (gen_done && done_at < 0) done_at = n;
        if (wr_en && first_wr < 0) first_wr = n * 16 + int'(wr_addr);
        if (cp_en && cp_first < 0) cp_first = n * 16 + int'(cp_addr);
      end else if (started) break;
      if (i == 199) timeouts++;
    end
    post("step_busy_len", busy_len, 34);
    post("step_gen_done_cycle", done_at, 18);
    post("step_gen_count", int'(gen_count), 1);
    post("row0_triple", t0_trip, (7 << 6) | (0 << 3) | 1);
    post("row7_triple", t7_trip, (6 << 6) | (7 << 3) | 0);
    post("first_write_cycle_addr", first_wr, 2 * 16 + 0);
    post("first_copy_cycle_addr", cp_first, 10 * 16 + 0);

    // Free run for three generations, then drop run during the fourth COPY
    do_reset();
    run = 1'b1;
    dones = 0; gaps = 0; gc3 = -1; started = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (busy) started = 1; else if (started) gaps++;
      if (gen_done) dones++;
      if (dones == 3) begin gc3 = int'(gen_count); break; end
      if (i == 399) timeouts++;
    end
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!busy) gaps++;
      if (cp_en) begin run = 1'b0; break; end
      if (i == 99) timeouts++;
    end
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (gen_done) dones++;
      if (!busy) break;
      if (i == 99) timeouts++;
    end
    gc4 = int'(gen_count);
    post("run3_gen_count", gc3, 3);
    post("run_no_idle_gap", gaps, 0);
    post("run_drop_dones", dones, 4);
    post("run_drop_gen_count", gc4, 4);
    post("run_drop_idle", int'(busy), 0);

    // load_req and step together in IDLE: LOAD wins, no strobes
    load_req = 1'b1; step = 1'b1;
    cyc();
    post("load_ack_high", int'(load_ack), 1);
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (wr_en || cp_en || busy || !load_ack) strobes++;
    end
    post("load_no_strobes", strobes, 0);
    load_req = 1'b0; step = 1'b0;
    cyc();
    post("load_released", int'(load_ack), 0);

    // Reset in cycle 5 of COMPUTE
    step = 1'b1; cyc(); step = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    reset = 1'b0;
    cyc();
    v = all_outs();
    reset = 1'b1;
    post("rst_mid_compute_all", v, 0);

    // Generation counter wrap with GENBITS=4
    do_reset();
    run = 1'b1;
    dones = 0; gc15 = -1; gc16 = -1;
    for (int i = 0; i < 700; i++) begin
      cyc();
      if (gen_done) begin
        dones++;
        if (dones == 15) gc15 = int'(gen_count);
        if (dones == 16) begin gc16 = int'(gen_count); break; end
      end
      if (i == 699) timeouts++;
    end
    run = 1'b0;
    post("wrap_count_15", gc15, 15);
    post("wrap_count_16", gc16, 0);

    // Random phase: the model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      step = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 14) == 0) load_req = ~load_req;
    end
    reset = 1'b1; run = 1'b0; step = 1'b0; load_req = 1'b0;
    cyc();

    post("no_timeouts", timeouts, 0);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
